mmu_seq: RTL

MMU_SEQ -- requirements
Module: mmu_seq

---
 rtl/mmu_pkg.sv | 20 ++
 rtl/mac_slice.sv | 25 ++
 rtl/mmu_seq.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mmu_pkg.sv
// Shared types and fixed-point helpers for the sequential matrix-multiply unit.
package mmu_pkg;

  typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

  // Wide enough that no partial sum over num_k products plus C can wrap.
  function automatic int unsigned acc_width(input int unsigned data_width,
                                            input int unsigned num_k);
    return 2 * data_width + $clog2(num_k) + 1;
  endfunction

  function automatic longint sat_max(input int unsigned data_width);
    return (longint'(1) <<< (data_width - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int unsigned data_width);
    return -(longint'(1) <<< (data_width - 1));
  endfunction

endpackage

// File: rtl/mac_slice.sv
// One output element: adds MACS fixed-point products (truncated toward -inf) to a running sum.
module mac_slice #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIXED_PNT  = 8,
  parameter int unsigned MACS       = 2,
  parameter int unsigned ACC_W      = 35
) (
  input  logic signed [DATA_WIDTH-1:0] a       [MACS],
  input  logic signed [DATA_WIDTH-1:0] b       [MACS],
  input  logic signed [ACC_W-1:0]      sum_in,
  output logic signed [ACC_W-1:0]      sum_out
);

  logic signed [2*DATA_WIDTH-1:0] prod;

  always_comb begin
    prod    = '0;
    sum_out = sum_in;
    for (int m = 0; m < MACS; m++) begin
      prod    = a[m] * b[m];
      sum_out = sum_out + ACC_W'(prod >>> FIXED_PNT);
    end
  end

endmodule

// File: rtl/mmu_seq.sv
// Sequential saturating fixed-point matrix multiply-accumulate: out = sat(C*accum_en + A x B).
module mmu_seq
  import mmu_pkg::*;
#(
  parameter int unsigned NUM_ROWS_A     = 2,
  parameter int unsigned NUM_COLS_A     = 4,
  parameter int unsigned NUM_COLS_B     = 2,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned FIXED_PNT      = 8,
  parameter int unsigned MACS_PER_CYCLE = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         accum_en,
  input  logic signed [DATA_WIDTH-1:0] mat_in1      [NUM_ROWS_A][NUM_COLS_A],
  input  logic signed [DATA_WIDTH-1:0] mat_in2      [NUM_COLS_A][NUM_COLS_B],
  input  logic signed [DATA_WIDTH-1:0] mat_in_accum [NUM_ROWS_A][NUM_COLS_B],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] mat_out      [NUM_ROWS_A][NUM_COLS_B],
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned NumSlices = NUM_COLS_A / MACS_PER_CYCLE;
  localparam int unsigned CntW      = $clog2(NumSlices + 1);
  localparam int unsigned AccW      = acc_width(DATA_WIDTH, NUM_COLS_A);
  localparam logic signed [AccW-1:0] SatMax = AccW'(sat_max(DATA_WIDTH));
  localparam logic signed [AccW-1:0] SatMin = AccW'(sat_min(DATA_WIDTH));

  if (NUM_COLS_A % MACS_PER_CYCLE != 0) begin : g_param_check
    $error("mmu_seq: MACS_PER_CYCLE must divide NUM_COLS_A");
  end

  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic load, last;

  logic signed [DATA_WIDTH-1:0] a_q       [NUM_ROWS_A][NUM_COLS_A];
  logic signed [DATA_WIDTH-1:0] b_q       [NUM_COLS_A][NUM_COLS_B];
  logic signed [AccW-1:0]       acc_q     [NUM_ROWS_A][NUM_COLS_B];
  logic signed [AccW-1:0]       sum_nxt   [NUM_ROWS_A][NUM_COLS_B];
  logic signed [DATA_WIDTH-1:0] sat_val   [NUM_ROWS_A][NUM_COLS_B];
  logic signed [DATA_WIDTH-1:0] mat_out_q [NUM_ROWS_A][NUM_COLS_B];
  logic ovf_any, unf_any, ovf_q, unf_q;

  // Operands shift down by MACS_PER_CYCLE each MAC cycle, so slices always read K-indices 0..M-1.
  for (genvar r = 0; r < NUM_ROWS_A; r++) begin : g_row
    for (genvar c = 0; c < NUM_COLS_B; c++) begin : g_col
      logic signed [DATA_WIDTH-1:0] a_s [MACS_PER_CYCLE];
      logic signed [DATA_WIDTH-1:0] b_s [MACS_PER_CYCLE];

      always_comb begin
        for (int m = 0; m < MACS_PER_CYCLE; m++) begin
          a_s[m] = a_q[r][m];
          b_s[m] = b_q[m][c];
        end
      end

      mac_slice #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIXED_PNT (FIXED_PNT),
        .MACS      (MACS_PER_CYCLE),
        .ACC_W     (AccW)
      ) u_mac_slice (
        .a      (a_s),
        .b      (b_s),
        .sum_in (acc_q[r][c]),
        .sum_out(sum_nxt[r][c])
      );
    end
  end

  assign last = (cnt_q == CntW'(NumSlices));

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    load     = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = StMac;
        end
      end
      StMac: begin
        if (last) state_d = StDone;
      end
      StDone: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            load    = 1'b1;
            state_d = StMac;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ovf_any = 1'b0;
    unf_any = 1'b0;
    for (int r = 0; r < NUM_ROWS_A; r++) begin
      for (int c = 0; c < NUM_COLS_B; c++) begin
        sat_val[r][c] = acc_q[r][c][DATA_WIDTH-1:0];
        if (acc_q[r][c] > SatMax) begin
          sat_val[r][c] = SatMax[DATA_WIDTH-1:0];
          ovf_any       = 1'b1;
        end else if (acc_q[r][c] < SatMin) begin
          sat_val[r][c] = SatMin[DATA_WIDTH-1:0];
          unf_any       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int r = 0; r < NUM_ROWS_A; r++) begin
        for (int k = 0; k < NUM_COLS_A; k++) a_q[r][k] <= '0;
        for (int c = 0; c < NUM_COLS_B; c++) begin
          acc_q[r][c]     <= '0;
          mat_out_q[r][c] <= '0;
        end
      end
      for (int k = 0; k < NUM_COLS_A; k++) begin
        for (int c = 0; c < NUM_COLS_B; c++) b_q[k][c] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (load) begin
        cnt_q <= '0;
        a_q   <= mat_in1;
        b_q   <= mat_in2;
        for (int r = 0; r < NUM_ROWS_A; r++) begin
          for (int c = 0; c < NUM_COLS_B; c++) begin
            acc_q[r][c] <= accum_en ? AccW'(mat_in_accum[r][c]) : '0;
          end
        end
      end else if (state_q == StMac) begin
        if (last) begin
          mat_out_q <= sat_val;
          ovf_q     <= ovf_any;
          unf_q     <= unf_any;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
          acc_q <= sum_nxt;
          for (int k = 0; k < NUM_COLS_A - MACS_PER_CYCLE; k++) begin
            for (int r = 0; r < NUM_ROWS_A; r++) a_q[r][k] <= a_q[r][k+MACS_PER_CYCLE];
            for (int c = 0; c < NUM_COLS_B; c++) b_q[k][c] <= b_q[k+MACS_PER_CYCLE][c];
          end
        end
      end
    end
  end

  assign out_valid = (state_q == StDone);
  assign mat_out   = mat_out_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
